decoder_driver: RTL and testbench
=================================

DECODER_DRIVER -- requirements
Module: decoder_driver

Interface
REQ-001 SHALL have parameters: WIDTH_IN, default 8, LLR width; N_LLRS, default 4, LLRs per input beat; WIDTH_OUT, default 8, output beat width; N_V, default 31, codeword length; TIMEOUT, default 1023, watchdog limit in cycles.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- frame_in  in  WIDTH_IN*N_V  LLR frame; LLR i at bits [i*WIDTH_IN +: WIDTH_IN].
- frame_valid  in  1  frame offered.
- frame_ready  out  1  frame accepted when high together with frame_valid.
- cw  out  N_V  decoded codeword.
- cw_valid  out  1  cw holds a result.
- cw_ready  in  1  consumer takes the result.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- dec_databus_in  out  N_LLRS*WIDTH_IN  LLR beat to the decoder.
- dec_first_data  out  1  first LLR beat marker.
- dec_data_valid  out  1  LLR beat valid.
- dec_busy  in  1  decoder busy.
- dec_out_ready  in  1  decoder result available.
- dec_first_data_out  out  1  readout request.
- dec_databus_out  in  WIDTH_OUT  result beat.
- dec_data_valid_out  in  1  result beat valid.

Function
REQ-003 SHALL implement FSM states IDLE, SEND, WAIT_RDY, REQ, COLLECT, DONE, with all outputs registered.
REQ-004 SHALL assert frame_ready only when in IDLE and dec_busy==0; on frame_valid&&frame_ready, the frame SHALL be captured and the FSM SHALL go to SEND.
REQ-005 SHALL send NB_IN=(N_V-1)/N_LLRS+1 beats (8 at defaults) in consecutive cycles, starting the cycle after acceptance, with dec_data_valid=1 for every beat and dec_first_data=1 on beat 0 only.
REQ-006 SHALL send LLRs most-significant first: beat 0 carries the top FC=((N_V-1)%N_LLRS+1) LLRs right-aligned and zero-padded above; each later beat carries the next N_LLRS LLRs in descending order; the last beat carries LLR N_LLRS-1..0.
REQ-007 SHALL go from SEND to WAIT_RDY after the last beat, driving dec_data_valid=0 and dec_first_data=0 outside SEND.
REQ-008 SHALL, in WAIT_RDY, go to REQ on dec_out_ready==1.
REQ-009 SHALL, in REQ, drive dec_first_data_out=1 for exactly one cycle and then go to COLLECT.
REQ-010 SHALL, in COLLECT, shift each dec_databus_out beat sampled with dec_data_valid_out==1 into the codeword MSB first: beat 0 contributes its low FCO=((N_V-1)%WIDTH_OUT+1) bits, later beats contribute WIDTH_OUT bits; non-valid cycles SHALL be ignored.
REQ-011 SHALL, after NB_OUT=(N_V-1)/WIDTH_OUT+1 beats (4 at defaults), load cw, set cw_valid=1 the following cycle, and enter DONE.
REQ-012 SHALL, in DONE, hold cw and cw_valid stable until cw_ready==1, then clear cw_valid and return to IDLE; cw_ready SHALL be ignored outside DONE.
REQ-013 SHALL use beat counters that never wrap; counters SHALL clear on every state exit.
REQ-014 SHALL ignore frame_valid in every state except IDLE, with frame_ready=0 there.

Reset
REQ-015 SHALL, while rst==0, immediately force state IDLE and drive frame_ready=0, cw=0, cw_valid=0, timeout_err=0, dec_databus_in=0, dec_first_data=0, dec_data_valid=0, dec_first_data_out=0, and clear all counters.
REQ-016 SHALL, on reset asserted mid-SEND or mid-COLLECT, abandon the partial frame or result; the first cycle after release SHALL be IDLE.

Configuration
REQ-017 SHALL, with DRV_TIMEOUT_EN defined, count cycles spent in WAIT_RDY or COLLECT; on reaching TIMEOUT it SHALL pulse timeout_err for one cycle and return to IDLE without setting cw_valid.
REQ-018 SHALL, without DRV_TIMEOUT_EN, exclude the watchdog counter entirely, tie timeout_err to 0, and wait indefinitely.

Verification
REQ-019 Load: LLR i = i, N_V=31 -> beats 32'h001E1D1C, 32'h1B1A1918, ..., 32'h03020100, with first_data on beat 0 only.
REQ-020 Readout: decoder model returns 8'h55, 8'hAA, 8'h0F, 8'hF0 -> cw=31'h55AA0FF0 and cw_valid one cycle after beat 4.
REQ-021 Back-pressure: dec_busy=1 with frame_valid=1 -> frame_ready=0 and no beats; dec_busy falls -> acceptance the same cycle.
REQ-022 Gaps: dec_data_valid_out toggles 1,0,1,0,... -> same cw as the gap-free case.
REQ-023 Hold: cw_ready=0 for 10 cycles -> cw stable and frame_ready=0; cw_ready=1 -> IDLE next cycle.
REQ-024 With DRV_TIMEOUT_EN and TIMEOUT=16: dec_out_ready never rises -> timeout_err pulse 16 cycles after entering WAIT_RDY, then IDLE; reset mid-SEND -> all outputs 0 immediately.

Source files
------------

// File: rtl/decoder_driver.sv
// -----------------------------------------------------------------------------
// decoder_driver
//
// Purpose:
//   Feeds one LLR frame to an external iterative decoder and collects the hard
//   decision codeword it returns.
//     1. A whole frame of N_V LLRs is accepted in one handshake.
//     2. The frame is streamed to the decoder as NB_IN consecutive beats of
//        N_LLRS LLRs, most-significant LLR first.
//     3. The block waits for the decoder to report a result.
//     4. It requests readout with a one-cycle pulse.
//     5. It gathers NB_OUT result beats, MSB first, and presents the codeword
//        until the consumer takes it.
//
// Ports:
//   clk, rst                   clock; asynchronous active-low reset
//   frame_in/_valid/_ready     frame input handshake (LLR i at [i*WIDTH_IN +: WIDTH_IN])
//   cw/cw_valid/cw_ready       codeword output handshake
//   timeout_err                one-cycle pulse when the watchdog aborts a frame
//   dec_databus_in, dec_first_data, dec_data_valid
//                              LLR beat stream towards the decoder
//   dec_busy, dec_out_ready    decoder status
//   dec_first_data_out         readout request pulse
//   dec_databus_out, dec_data_valid_out
//                              result beat stream from the decoder
//
// Configuration:
//   DRV_TIMEOUT_EN  when defined, a watchdog counts cycles spent in WAIT_RDY or
//                   COLLECT. On reaching TIMEOUT it pulses timeout_err and
//                   returns to IDLE without producing a codeword. When
//                   undefined, the block waits indefinitely and timeout_err
//                   is tied low.
// -----------------------------------------------------------------------------
module decoder_driver #(
  parameter int unsigned WIDTH_IN  = 8,
  parameter int unsigned N_LLRS    = 4,
  parameter int unsigned WIDTH_OUT = 8,
  parameter int unsigned N_V       = 31,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH_IN*N_V-1:0]    frame_in,
  input  logic                       frame_valid,
  output logic                       frame_ready,
  output logic [N_V-1:0]             cw,
  output logic                       cw_valid,
  input  logic                       cw_ready,
  output logic                       timeout_err,
  output logic [N_LLRS*WIDTH_IN-1:0] dec_databus_in,
  output logic                       dec_first_data,
  output logic                       dec_data_valid,
  input  logic                       dec_busy,
  input  logic                       dec_out_ready,
  output logic                       dec_first_data_out,
  input  logic [WIDTH_OUT-1:0]       dec_databus_out,
  input  logic                       dec_data_valid_out
);

  // Beat geometry. The frame is zero-extended at the top to a whole number of
  // beats. As a result, the short first beat comes out of the same slicing as
  // every other beat.
  localparam int unsigned NB_IN     = (N_V - 1) / N_LLRS + 1;
  localparam int unsigned NB_OUT    = (N_V - 1) / WIDTH_OUT + 1;
  localparam int unsigned BEAT_W    = N_LLRS * WIDTH_IN;
  localparam int unsigned FRAME_W   = N_V * WIDTH_IN;
  localparam int unsigned PAD_W     = NB_IN * BEAT_W;
  localparam int unsigned ACC_W     = NB_OUT * WIDTH_OUT;
  localparam int unsigned IN_CNT_W  = $clog2(NB_IN + 1);
  localparam int unsigned OUT_CNT_W = $clog2(NB_OUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_RDY,
    REQ,
    COLLECT,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic [IN_CNT_W-1:0]    in_cnt_q, in_cnt_d;
  logic [OUT_CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [PAD_W-1:0]       frame_q, frame_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [BEAT_W-1:0]      databus_in_q, databus_in_d;
  logic                   first_data_q, first_data_d;
  logic                   data_valid_q, data_valid_d;
  logic                   first_out_q, first_out_d;
  logic [N_V-1:0]         cw_q, cw_d;
  logic                   cw_valid_q, cw_valid_d;

  logic [PAD_W-1:0]       frame_pad;
  logic [ACC_W-1:0]       acc_shift;
  logic                   wd_expire;

  // ready_q is a registered "FSM is idle" flag. Gating it with the live
  // dec_busy means a frame is only ever accepted while the decoder is free,
  // and it is accepted in the very cycle dec_busy falls.
  assign frame_ready = ready_q & ~dec_busy;

  // NOTE: every variable assigned in always_comb gets a default at the top of
  // the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    frame_d      = frame_q;
    acc_d        = acc_q;
    databus_in_d = '0;
    first_data_d = 1'b0;
    data_valid_d = 1'b0;
    first_out_d  = 1'b0;
    cw_d         = cw_q;
    cw_valid_d   = cw_valid_q;

    frame_pad                = '0;
    frame_pad[FRAME_W-1:0]   = frame_in;
    acc_shift                = (acc_q << WIDTH_OUT) | ACC_W'(dec_databus_out);

    case (state_q)
      IDLE: begin
        if (frame_valid && frame_ready) begin
          // Beat 0 is registered on the accepting edge. The remaining beats
          // wait in frame_q, already shifted so that the next one is on top.
          state_d      = SEND;
          databus_in_d = frame_pad[PAD_W-1 -: BEAT_W];
          frame_d      = frame_pad << BEAT_W;
          first_data_d = 1'b1;
          data_valid_d = 1'b1;
          in_cnt_d     = IN_CNT_W'(1);
        end
      end

      SEND: begin
        // in_cnt_q counts beats already on the bus. Once all NB_IN beats have
        // been shown, the bus drops and the FSM waits for the decoder.
        if (in_cnt_q == IN_CNT_W'(NB_IN)) begin
          state_d  = WAIT_RDY;
          in_cnt_d = '0;
          frame_d  = '0;
        end else begin
          databus_in_d = frame_q[PAD_W-1 -: BEAT_W];
          frame_d      = frame_q << BEAT_W;
          data_valid_d = 1'b1;
          in_cnt_d     = in_cnt_q + 1'b1;
        end
      end

      WAIT_RDY: begin
        if (wd_expire) begin
          state_d = IDLE;
        end else if (dec_out_ready) begin
          state_d     = REQ;
          first_out_d = 1'b1;
        end
      end

      REQ: begin
        state_d = COLLECT;
      end

      COLLECT: begin
        if (wd_expire) begin
          state_d   = IDLE;
          out_cnt_d = '0;
          acc_d     = '0;
        end else if (dec_data_valid_out) begin
          // Bits of the first beat above FCO are shifted past the top of the
          // codeword and dropped by the final truncation to N_V bits.
          if (out_cnt_q == OUT_CNT_W'(NB_OUT - 1)) begin
            state_d    = DONE;
            cw_d       = acc_shift[N_V-1:0];
            cw_valid_d = 1'b1;
            out_cnt_d  = '0;
            acc_d      = '0;
          end else begin
            acc_d     = acc_shift;
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        if (cw_ready) begin
          state_d    = IDLE;
          cw_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: the frame shift register and result accumulator are reset along
  // with the control state, so an aborted frame leaves no stale LLRs or
  // partial codeword behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      frame_q      <= '0;
      acc_q        <= '0;
      databus_in_q <= '0;
      first_data_q <= 1'b0;
      data_valid_q <= 1'b0;
      first_out_q  <= 1'b0;
      cw_q         <= '0;
      cw_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      frame_q      <= frame_d;
      acc_q        <= acc_d;
      databus_in_q <= databus_in_d;
      first_data_q <= first_data_d;
      data_valid_q <= data_valid_d;
      first_out_q  <= first_out_d;
      cw_q         <= cw_d;
      cw_valid_q   <= cw_valid_d;
    end
  end

  assign dec_databus_in     = databus_in_q;
  assign dec_first_data     = first_data_q;
  assign dec_data_valid     = data_valid_q;
  assign dec_first_data_out = first_out_q;
  assign cw                 = cw_q;
  assign cw_valid           = cw_valid_q;

`ifdef DRV_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_err_q;
  logic            wd_active;

  // The count restarts on every state change. Cycles spent in WAIT_RDY and in
  // COLLECT are therefore each limited to TIMEOUT on their own. The counter
  // leaves the state at TIMEOUT-1 and so never wraps.
  assign wd_active = (state_q == WAIT_RDY) || (state_q == COLLECT);
  assign wd_expire = wd_active && (wd_cnt_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    wd_cnt_d = '0;
    if (wd_active && (state_d == state_q)) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= wd_expire;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  // No watchdog: the FSM waits for the decoder indefinitely. TIMEOUT only
  // matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign wd_expire      = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_driver.sv
// -----------------------------------------------------------------------------
// tb_decoder_driver
//
// Directed bench for decoder_driver at default geometry (TIMEOUT=16).
//
// A monitor compares every LLR beat and every new codeword against a
// stream-level model:
//   - LLRs are queued in send order and packed into beats.
//   - Codeword bits are mapped from result beats by position.
//
// Hand-computed literals pin the model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decoder_driver;

  localparam int WIDTH_IN  = 8;
  localparam int N_LLRS    = 4;
  localparam int WIDTH_OUT = 8;
  localparam int N_V       = 31;
  localparam int TIMEOUT   = 16;
  localparam int NB_IN     = (N_V - 1) / N_LLRS + 1;
  localparam int NB_OUT    = (N_V - 1) / WIDTH_OUT + 1;
  localparam int BEAT_W    = N_LLRS * WIDTH_IN;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [WIDTH_IN*N_V-1:0]   frame_in = '0;
  logic                      frame_valid = 1'b0;
  logic                      frame_ready;
  logic [N_V-1:0]            cw;
  logic                      cw_valid;
  logic                      cw_ready = 1'b0;
  logic                      timeout_err;
  logic [BEAT_W-1:0]         dec_databus_in;
  logic                      dec_first_data;
  logic                      dec_data_valid;
  logic                      dec_busy = 1'b0;
  logic                      dec_out_ready = 1'b0;
  logic                      dec_first_data_out;
  logic [WIDTH_OUT-1:0]      dec_databus_out = '0;
  logic                      dec_data_valid_out = 1'b0;

  always #5 clk = ~clk;

  decoder_driver #(
    .WIDTH_IN  (WIDTH_IN),
    .N_LLRS    (N_LLRS),
    .WIDTH_OUT (WIDTH_OUT),
    .N_V       (N_V),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .frame_in           (frame_in),
    .frame_valid        (frame_valid),
    .frame_ready        (frame_ready),
    .cw                 (cw),
    .cw_valid           (cw_valid),
    .cw_ready           (cw_ready),
    .timeout_err        (timeout_err),
    .dec_databus_in     (dec_databus_in),
    .dec_first_data     (dec_first_data),
    .dec_data_valid     (dec_data_valid),
    .dec_busy           (dec_busy),
    .dec_out_ready      (dec_out_ready),
    .dec_first_data_out (dec_first_data_out),
    .dec_databus_out    (dec_databus_out),
    .dec_data_valid_out (dec_data_valid_out)
  );

  typedef struct packed {
    logic              first;
    logic [BEAT_W-1:0] data;
  } beat_t;

  beat_t              exp_beats[$];
  logic [N_V-1:0]     exp_cws[$];
  logic [BEAT_W-1:0]  beat_log[$];
  logic [WIDTH_IN-1:0] llr[N_V];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model
  // ---------------------------------------------------------------------------
  // The decoder sees the LLRs as one stream from N_V-1 down to 0, preceded by
  // zero padding that fills the first beat. Each beat takes the next N_LLRS
  // stream entries, the earliest in the most-significant lane.
  function automatic void model_frame();
    logic [WIDTH_IN-1:0] seq[$];
    int pad;
    pad = NB_IN * N_LLRS - N_V;
    for (int i = 0; i < pad; i++) seq.push_back('0);
    for (int i = N_V - 1; i >= 0; i--) seq.push_back(llr[i]);
    for (int k = 0; k < NB_IN; k++) begin
      beat_t e;
      e.first = (k == 0);
      e.data  = '0;
      for (int j = 0; j < N_LLRS; j++) begin
        e.data = {e.data[BEAT_W-WIDTH_IN-1:0], seq.pop_front()};
      end
      exp_beats.push_back(e);
    end
  endfunction

  // Codeword bit j comes from result beat NB_OUT-1-j/WIDTH_OUT, bit j%WIDTH_OUT.
  function automatic logic [N_V-1:0] model_cw(input logic [WIDTH_OUT-1:0] b0, b1, b2, b3);
    logic [WIDTH_OUT-1:0] bs[NB_OUT];
    logic [N_V-1:0] c;
    bs = '{b0, b1, b2, b3};
    c  = '0;
    for (int j = 0; j < N_V; j++) c[j] = bs[NB_OUT - 1 - j / WIDTH_OUT][j % WIDTH_OUT];
    return c;
  endfunction

  task automatic load_llrs(input int mode);
    for (int i = 0; i < N_V; i++) begin
      case (mode)
        0:       llr[i] = WIDTH_IN'(i);
        1:       llr[i] = WIDTH_IN'(i * 37 + 11);
        default: llr[i] = WIDTH_IN'(255 - i);
      endcase
      frame_in[i*WIDTH_IN +: WIDTH_IN] = llr[i];
    end
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: every valid beat and every newly valid codeword
  // ---------------------------------------------------------------------------
  beat_t mon_e;
  logic  cw_valid_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      cw_valid_prev = 1'b0;
    end else begin
      if (dec_data_valid) begin
        beat_log.push_back(dec_databus_in);
        check("beat_expected", 64'(exp_beats.size() != 0), 64'd1);
        if (exp_beats.size() != 0) begin
          mon_e = exp_beats.pop_front();
          check("beat_data", dec_databus_in, mon_e.data);
          check("beat_first", dec_first_data, mon_e.first);
        end
      end else begin
        check("first_data_outside_beat", dec_first_data, 1'b0);
      end
      if (cw_valid && !cw_valid_prev) begin
        check("cw_expected", 64'(exp_cws.size() != 0), 64'd1);
        if (exp_cws.size() != 0) check("cw_model", cw, exp_cws.pop_front());
      end
      cw_valid_prev = cw_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 ns after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic send_frame(input int mode);
    int cyc;
    load_llrs(mode);
    model_frame();
    frame_valid = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!frame_ready && cyc < 20);
    check("frame_accept", frame_ready, 1'b1);
    @(posedge clk); #1;
    frame_valid = 1'b0;
  endtask

  task automatic decode(input logic [WIDTH_OUT-1:0] b0, b1, b2, b3, input bit gaps);
    logic [WIDTH_OUT-1:0] bs[NB_OUT];
    int cyc;
    bs = '{b0, b1, b2, b3};
    exp_cws.push_back(model_cw(b0, b1, b2, b3));
    dec_out_ready = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!dec_first_data_out && cyc < 50);
    check("readout_request", dec_first_data_out, 1'b1);
    @(posedge clk); #1;
    dec_out_ready = 1'b0;
    for (int i = 0; i < NB_OUT; i++) begin
      dec_data_valid_out = 1'b1;
      dec_databus_out    = bs[i];
      @(negedge clk);
      check("readout_request_one_cycle", dec_first_data_out, 1'b0);
      check("cw_valid_early", cw_valid, 1'b0);
      @(posedge clk); #1;
      if (gaps && i < NB_OUT - 1) begin
        dec_data_valid_out = 1'b0;
        dec_databus_out    = ~bs[i];
        @(posedge clk); #1;
      end
    end
    dec_data_valid_out = 1'b0;
    dec_databus_out    = '0;
    @(negedge clk);
    check("cw_valid_after_last_beat", cw_valid, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int cyc;
    logic seen_to, seen_ready;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_frame_ready", frame_ready, 1'b0);
    check("rst_cw", cw, '0);
    check("rst_cw_valid", cw_valid, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_databus_in", dec_databus_in, '0);
    check("rst_first_data", dec_first_data, 1'b0);
    check("rst_data_valid", dec_data_valid, 1'b0);
    check("rst_first_data_out", dec_first_data_out, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_frame_ready", frame_ready, 1'b1);
    @(posedge clk); #1;

    // Load LLR i = i, readout 55 AA 0F F0, no gaps
    beat_log.delete();
    send_frame(0);
    decode(8'h55, 8'hAA, 8'h0F, 8'hF0, 1'b0);
    check("beat_count", beat_log.size(), NB_IN);
    if (beat_log.size() == NB_IN) begin
      check("beat0_literal", beat_log[0], 32'h001E1D1C);
      check("beat1_literal", beat_log[1], 32'h1B1A1918);
      check("beat7_literal", beat_log[7], 32'h03020100);
    end
    check("cw_literal_a", cw, 31'h55AA0FF0);

    // Hold: cw stays put and no new frame is taken while cw_ready is low
    @(posedge clk); #1;
    frame_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("hold_cw", cw, 31'h55AA0FF0);
      check("hold_cw_valid", cw_valid, 1'b1);
      check("hold_frame_ready", frame_ready, 1'b0);
    end
    @(posedge clk); #1;
    cw_ready    = 1'b1;
    frame_valid = 1'b0;
    @(posedge clk); #1;
    cw_ready = 1'b0;
    @(negedge clk);
    check("release_cw_valid", cw_valid, 1'b0);
    check("release_idle", frame_ready, 1'b1);

    // Back-pressure, then a readout with valid gaps; cw_ready held high early
    @(posedge clk); #1;
    dec_busy = 1'b1;
    load_llrs(1);
    frame_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("busy_frame_ready", frame_ready, 1'b0);
      check("busy_no_beat", dec_data_valid, 1'b0);
    end
    @(posedge clk); #1;
    dec_busy = 1'b0;
    @(negedge clk);
    check("busy_fall_ready", frame_ready, 1'b1);
    model_frame();
    @(posedge clk); #1;
    frame_valid = 1'b0;
    cw_ready    = 1'b1;
    decode(8'h12, 8'h34, 8'h56, 8'h78, 1'b1);
    check("cw_literal_b", cw, 31'h12345678);
    @(negedge clk);
    check("cw_valid_one_cycle", cw_valid, 1'b0);
    check("cw_held_after_take", cw, 31'h12345678);
    @(posedge clk); #1;
    cw_ready = 1'b0;

`ifdef DRV_TIMEOUT_EN
    // Watchdog: decoder never reports ready
    send_frame(1);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (dec_data_valid && cyc < 40);
    cyc = 1;  // this sample is the first WAIT_RDY cycle
    while (!timeout_err && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout_cycle", cyc, 17);
    check("timeout_idle", frame_ready, 1'b1);
    check("timeout_no_cw", cw_valid, 1'b0);
    @(negedge clk);
    check("timeout_pulse_width", timeout_err, 1'b0);
    @(posedge clk); #1;
`else
    // No watchdog: waits indefinitely, then finishes normally
    send_frame(1);
    seen_to = 1'b0;
    seen_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen_to    = seen_to | timeout_err;
      seen_ready = seen_ready | frame_ready;
    end
    check("no_watchdog_timeout", seen_to, 1'b0);
    check("no_watchdog_still_busy", seen_ready, 1'b0);
    @(posedge clk); #1;
    cw_ready = 1'b1;
    decode(8'h3C, 8'hC3, 8'h5A, 8'hA5, 1'b0);
    check("cw_literal_c", cw, 31'h3CC35AA5);
    @(posedge clk); #1;
    cw_ready = 1'b0;
`endif

    // Reset mid-SEND
    send_frame(2);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    exp_beats.delete();
    #1;
    check("midrst_data_valid", dec_data_valid, 1'b0);
    check("midrst_first_data", dec_first_data, 1'b0);
    check("midrst_databus_in", dec_databus_in, '0);
    check("midrst_frame_ready", frame_ready, 1'b0);
    check("midrst_cw_valid", cw_valid, 1'b0);
    check("midrst_cw", cw, '0);
    check("midrst_timeout_err", timeout_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_no_beat", dec_data_valid, 1'b0);
    @(negedge clk);
    check("post_rst_idle", frame_ready, 1'b1);
    @(posedge clk); #1;

    // Recovery frame, LLR i = 255-i, readout F0 0F AA 55
    cw_ready = 1'b1;
    send_frame(2);
    decode(8'hF0, 8'h0F, 8'hAA, 8'h55, 1'b0);
    check("cw_literal_d", cw, 31'h700FAA55);
    repeat (2) @(negedge clk);
    check("leftover_beats", exp_beats.size(), 0);
    check("leftover_cws", exp_cws.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
